// File: rtl/bus_arb_pkg.sv
// Shared types and defaults for the serial bus arbiter.
// Optional feature macro: ARB_ROUND_ROBIN_EN (see serial_bus_arbiter.sv).
package bus_arb_pkg;

  localparam int DEF_NUM_MASTERS = 3;
  localparam int DEF_MAX_HOLD    = 64;
  localparam int MAX_MASTERS     = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

  // Index of the set bit in a one-hot vector; 0 when the vector is empty.
  function automatic int onehot_to_idx(input logic [MAX_MASTERS-1:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_MASTERS; i++)
      if (oh[i]) idx = i;
    return idx;
  endfunction

endpackage

// File: rtl/serial_bus_arbiter_if.sv
// Request/grant bundle between the bus masters and the arbiter.
// slave modport: arbiter side. master modport: requester/environment side.
interface serial_bus_arbiter_if
  import bus_arb_pkg::*;
#(
  parameter int NUM_MASTERS = DEF_NUM_MASTERS
) ();
  localparam int IW = $clog2(NUM_MASTERS);

  logic [NUM_MASTERS-1:0] req;
  logic                   slave_busy;
  logic [NUM_MASTERS-1:0] grant;
  logic                   bus_util;
  logic                   timeout_pulse;
  logic [IW-1:0]          owner_id;

  modport slave (
    input  req, slave_busy,
    output grant, bus_util, timeout_pulse, owner_id
  );

  modport master (
    output req, slave_busy,
    input  grant, bus_util, timeout_pulse, owner_id
  );
endinterface

// File: rtl/arb_priority_pick.sv
// Combinational winner search: first set bit of req_masked found by scanning
// upward from start, wrapping at NUM_MASTERS. Output is one-hot or zero.
module arb_priority_pick #(
  parameter int NUM_MASTERS = 3,
  parameter int IDX_W       = 2
) (
  input  logic [NUM_MASTERS-1:0] req_masked,
  input  logic [IDX_W-1:0]       start,
  output logic [NUM_MASTERS-1:0] winner
);

  // Rotating first-one search; only the first hit is marked.
  always_comb begin
    int   idx;
    logic found;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      idx = int'(start) + k;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      if (!found && req_masked[IDX_W'(idx)]) begin
        winner[IDX_W'(idx)] = 1'b1;
        found               = 1'b1;
      end
    end
  end

endmodule

// File: rtl/serial_bus_arbiter.sv
// Serial bus arbiter: one-hot grant to one master at a time, one-cycle
// turnaround between owners, and a hold watchdog that revokes and locks out
// a master that keeps the bus too long (slave-busy cycles are not counted).
// Define ARB_ROUND_ROBIN_EN to rotate priority from the last winner; default
// build is fixed priority (lowest index wins) with no pointer register.
module serial_bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NUM_MASTERS = DEF_NUM_MASTERS,
  parameter int MAX_HOLD    = DEF_MAX_HOLD,
  parameter int HOLD_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  serial_bus_arbiter_if.slave   bus
);
  localparam int IW = $clog2(NUM_MASTERS);
  localparam logic [HOLD_WIDTH-1:0] HOLD_LAST = HOLD_WIDTH'(MAX_HOLD - 1);

  arb_state_e             state;
  logic [HOLD_WIDTH-1:0]  hold_cnt;
  logic [NUM_MASTERS-1:0] lockout;
  logic [NUM_MASTERS-1:0] grant_q;
  logic                   util_q;
  logic                   timeout_q;
  logic [IW-1:0]          owner_q;

  logic [NUM_MASTERS-1:0] avail;
  logic [NUM_MASTERS-1:0] winner;
  logic [IW-1:0]          winner_id;
  logic [IW-1:0]          start_ptr;
  logic                   owner_req;

  assign avail     = bus.req & ~lockout;
  assign owner_req = |(bus.req & grant_q);
  assign winner_id = IW'(onehot_to_idx(MAX_MASTERS'(winner)));

`ifdef ARB_ROUND_ROBIN_EN
  logic [IW-1:0] last_ptr;
  assign start_ptr = (last_ptr == IW'(NUM_MASTERS - 1)) ? '0 : last_ptr + 1'b1;
`else
  assign start_ptr = '0;
`endif

  arb_priority_pick #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDX_W       (IW)
  ) u_pick (
    .req_masked (avail),
    .start      (start_ptr),
    .winner     (winner)
  );

  assign bus.grant         = grant_q;
  assign bus.bus_util      = util_q;
  assign bus.timeout_pulse = timeout_q;
  assign bus.owner_id      = owner_q;

  // Arbitration FSM with registered grant/util/pulse outputs and lockout.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      lockout   <= '0;
      grant_q   <= '0;
      util_q    <= 1'b0;
      timeout_q <= 1'b0;
      owner_q   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_ptr  <= '0;
`endif
    end else begin
      timeout_q <= 1'b0;
      // A locked-out master is forgiven once it is seen with req low.
      lockout   <= lockout & bus.req;
      case (state)
        IDLE: begin
          if (!bus.slave_busy && |avail) begin
            grant_q  <= winner;
            util_q   <= 1'b1;
            owner_q  <= winner_id;
            hold_cnt <= '0;
            state    <= GRANTED;
`ifdef ARB_ROUND_ROBIN_EN
            last_ptr <= winner_id;
`endif
          end
        end
        GRANTED: begin
          if (!owner_req) begin
            grant_q <= '0;
            util_q  <= 1'b0;
            state   <= RELEASE;
          end else if (hold_cnt == HOLD_LAST) begin
            grant_q   <= '0;
            util_q    <= 1'b0;
            timeout_q <= 1'b1;
            lockout   <= (lockout & bus.req) | grant_q;
            state     <= RELEASE;
          end else if (!bus.slave_busy) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        RELEASE: state <= IDLE;
        default: begin
          state   <= IDLE;
          grant_q <= '0;
          util_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// Self-checking bench for serial_bus_arbiter: a bus-phase reference model
// (owner / hold count / turnaround / lockout set) is compared against the DUT
// every cycle, plus directed literal expectations and randomized traffic.
module tb_serial_bus_arbiter;
  localparam int N    = 3;
  localparam int HOLD = 8;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  serial_bus_arbiter_if #(.NUM_MASTERS(N)) bus ();

  serial_bus_arbiter #(
    .NUM_MASTERS (N),
    .MAX_HOLD    (HOLD),
    .HOLD_WIDTH  (4)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference model: who owns the bus, how many non-busy cycles it has used,
  // whether we are in the turnaround gap, and who is locked out.
  int         m_owner = -1;
  int         m_used  = 0;
  int         m_last  = 0;
  bit         m_turn  = 1'b0;
  logic [N-1:0] m_lock    = '0;
  logic [N-1:0] exp_grant = '0;
  logic         exp_to    = 1'b0;
  logic [1:0]   exp_owner = '0;

  always @(posedge clk or negedge rstn) begin : model
    int own, used, last, start, i;
    bit turn, to;
    logic [N-1:0] lk, r, sel;
    if (!rstn) begin
      m_owner   <= -1;
      m_used    <= 0;
      m_last    <= 0;
      m_turn    <= 1'b0;
      m_lock    <= '0;
      exp_grant <= '0;
      exp_to    <= 1'b0;
      exp_owner <= '0;
    end else begin
      own = m_owner; used = m_used; last = m_last; turn = m_turn; to = 1'b0;
      r   = bus.req;
      lk  = m_lock & r;
      sel = (own >= 0) ? (N'(1) << own) : '0;
      if (turn) begin
        turn = 1'b0;
      end else if (own >= 0) begin
        if ((r & sel) == '0) begin
          own = -1; turn = 1'b1;
        end else if (used == HOLD - 1) begin
          lk = lk | sel; to = 1'b1; own = -1; turn = 1'b1;
        end else if (!bus.slave_busy) begin
          used++;
        end
      end else if (!bus.slave_busy) begin
`ifdef ARB_ROUND_ROBIN_EN
        start = (last + 1) % N;
`else
        start = 0;
`endif
        for (int k = 0; k < N; k++) begin
          i = (start + k) % N;
          if (own < 0 && r[i] && !m_lock[i]) begin
            own = i; used = 0; last = i;
            exp_owner <= 2'(i);
          end
        end
      end
      m_owner   <= own;
      m_used    <= used;
      m_last    <= last;
      m_turn    <= turn;
      m_lock    <= lk;
      exp_grant <= (own >= 0) ? (N'(1) << own) : '0;
      exp_to    <= to;
    end
  end

  // Every-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    chk("grant",         32'(bus.grant),          32'(exp_grant));
    chk("bus_util",      32'(bus.bus_util),       32'(|exp_grant));
    chk("timeout_pulse", 32'(bus.timeout_pulse),  32'(exp_to));
    chk("owner_id",      32'(bus.owner_id),       32'(exp_owner));
    chk("grant_onehot",  32'($onehot0(bus.grant)), 32'd1);
  end

  initial begin
    int order [3];
    logic [N-1:0] r;
    logic [N-1:0] first;
    bus.req        = '0;
    bus.slave_busy = 1'b0;

    // Reset with all requests high: nothing granted until release.
    bus.req = 3'b111;
    cyc(3);
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_util",  32'(bus.bus_util), 32'd0);
    rstn = 1'b1;
    cyc(1);
`ifdef ARB_ROUND_ROBIN_EN
    chk("rst_first_grant", 32'(bus.grant), 32'b010);
`else
    chk("rst_first_grant", 32'(bus.grant), 32'b001);
`endif
    bus.req = '0;
    cyc(3);

    // Single master: grant one cycle after req, drop -> turnaround.
    bus.req = 3'b010;
    cyc(1);
    chk("single_grant", 32'(bus.grant), 32'b010);
    chk("single_util",  32'(bus.bus_util), 32'd1);
    cyc(4);
    bus.req = '0;
    cyc(1);
    chk("single_drop_grant", 32'(bus.grant), 32'd0);
    chk("single_drop_util",  32'(bus.bus_util), 32'd0);
    cyc(1);
    chk("single_idle_grant", 32'(bus.grant), 32'd0);
    cyc(1);

    // Contention: each owner holds 3 cycles, then two empty cycles.
`ifdef ARB_ROUND_ROBIN_EN
    order = '{2, 0, 1};
`else
    order = '{0, 1, 2};
`endif
    bus.req = 3'b111;
    for (int m = 0; m < 3; m++) begin
      cyc(1);
      chk("contend_grant", 32'(bus.grant), 32'd1 << order[m]);
      cyc(2);
      bus.req[order[m]] = 1'b0;
      cyc(1);
      chk("contend_gap1", 32'(bus.grant), 32'd0);
      cyc(1);
      chk("contend_gap2", 32'(bus.grant), 32'd0);
    end

    // Master 0 served, then 101 requested.
    bus.req = 3'b001;
    cyc(1);
    chk("m0_grant", 32'(bus.grant), 32'b001);
    bus.req = '0;
    cyc(2);
    bus.req = 3'b101;
    cyc(1);
`ifdef ARB_ROUND_ROBIN_EN
    chk("pair_first", 32'(bus.grant), 32'b100);
`else
    chk("pair_first", 32'(bus.grant), 32'b001);
`endif
    first   = bus.grant;
    bus.req = 3'b101 & ~first;
    cyc(3);
    chk("pair_second", 32'(bus.grant), 32'(3'b101 & ~first));
    bus.req = '0;
    cyc(3);

    // Watchdog: 8 granted cycles, revoke + pulse on the 9th, then lockout.
    bus.req = 3'b100;
    for (int c = 1; c <= 9; c++) begin
      cyc(1);
      if (c == 8) chk("wd_last_grant", 32'(bus.grant), 32'b100);
      if (c == 9) begin
        chk("wd_revoke_grant", 32'(bus.grant), 32'd0);
        chk("wd_pulse",        32'(bus.timeout_pulse), 32'd1);
      end
    end
    cyc(1);
    chk("wd_pulse_end", 32'(bus.timeout_pulse), 32'd0);
    cyc(3);
    chk("wd_locked", 32'(bus.grant), 32'd0);
    bus.req = 3'b101;
    cyc(1);
    chk("wd_other_granted", 32'(bus.grant), 32'b001);
    bus.req = '0;
    cyc(3);

    // Watchdog with 5 busy cycles: hold stretches to 13 cycles.
    bus.req = 3'b100;
    for (int c = 1; c <= 14; c++) begin
      cyc(1);
      bus.slave_busy = (c >= 2 && c <= 6);
      if (c == 13) chk("wd_busy_last", 32'(bus.grant), 32'b100);
      if (c == 14) begin
        chk("wd_busy_revoke", 32'(bus.grant), 32'd0);
        chk("wd_busy_pulse",  32'(bus.timeout_pulse), 32'd1);
      end
    end
    bus.req = '0;
    cyc(3);

    // Busy gate in IDLE, then asynchronous reset mid-grant.
    bus.slave_busy = 1'b1;
    bus.req        = 3'b001;
    cyc(3);
    chk("busy_gate", 32'(bus.grant), 32'd0);
    bus.slave_busy = 1'b0;
    cyc(1);
    chk("busy_gate_release", 32'(bus.grant), 32'b001);
    #2;
    rstn = 1'b0;
    #1;
    chk("async_rst_grant", 32'(bus.grant), 32'd0);
    chk("async_rst_util",  32'(bus.bus_util), 32'd0);
    @(posedge clk);
    #1;
    rstn    = 1'b1;
    bus.req = '0;
    cyc(2);

    // Randomized traffic against the model.
    r = '0;
    repeat (3000) begin
      for (int i = 0; i < N; i++) begin
        if (r[i]) begin
          if ($urandom_range(0, 15) == 0) r[i] = 1'b0;
        end else if ($urandom_range(0, 5) == 0) begin
          r[i] = 1'b1;
        end
      end
      bus.req        = r;
      bus.slave_busy = ($urandom_range(0, 3) == 0);
      cyc(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
